// File: rtl/digit_feature_gen.sv
// rtl/digit_feature_gen.sv - digit class to (edges, curves) feature generator
// Single requests or a 0..9 self-test sweep, presented on a valid/ready stream.
module digit_feature_gen #(
   parameter int unsigned SWEEP_GAP = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] in_digit,
   output logic       in_ready,
   input  logic       sweep_start,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_edges,
   output logic [3:0] out_curves,
   output logic [3:0] out_digit,
   output logic       out_last,
   output logic       err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_GAP,
      S_SWEEP_HOLD
   } state_t;

   localparam logic [3:0] GAP_LAST = 4'(SWEEP_GAP - 1);

   state_t     r_state;
   logic [3:0] r_sweep_digit;
   logic [3:0] r_gap_cnt;
   logic       r_out_valid;
   logic [2:0] r_out_edges;
   logic [3:0] r_out_curves;
   logic [3:0] r_out_digit;
   logic       r_out_last;
   logic       r_err;

   logic [3:0] w_next_digit;

   // Packed as {edges[2:0], curves[3:0]}; illegal digits never reach the table.
   function automatic logic [6:0] feature(input logic [3:0] d);
      case (d)
         4'd0:    feature = {3'd0, 4'd4};
         4'd1:    feature = {3'd1, 4'd0};
         4'd2:    feature = {3'd1, 4'd1};
         4'd3:    feature = {3'd0, 4'd2};
         4'd4:    feature = {3'd3, 4'd0};
         4'd5:    feature = {3'd2, 4'd1};
         4'd6:    feature = {3'd0, 4'd3};
         4'd7:    feature = {3'd2, 4'd0};
         4'd8:    feature = {3'd0, 4'd6};
         4'd9:    feature = {3'd1, 4'd2};
         default: feature = 7'd0;
      endcase
   endfunction

   assign w_next_digit = r_sweep_digit + 4'd1;

   assign in_ready   = (r_state == S_IDLE);
   assign out_valid  = r_out_valid;
   assign out_edges  = r_out_edges;
   assign out_curves = r_out_curves;
   assign out_digit  = r_out_digit;
   assign out_last   = r_out_last;
   assign err        = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_sweep_digit <= 4'd0;
         r_gap_cnt     <= 4'd0;
         r_out_valid   <= 1'b0;
         r_out_edges   <= 3'd0;
         r_out_curves  <= 4'd0;
         r_out_digit   <= 4'd0;
         r_out_last    <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (sweep_start) begin
                  r_state                      <= S_SWEEP_HOLD;
                  r_sweep_digit                <= 4'd0;
                  {r_out_edges, r_out_curves}  <= feature(4'd0);
                  r_out_digit                  <= 4'd0;
                  r_out_last                   <= 1'b0;
                  r_out_valid                  <= 1'b1;
               end else if (in_valid) begin
                  if (in_digit <= 4'd9) begin
                     r_state                     <= S_HOLD;
                     {r_out_edges, r_out_curves} <= feature(in_digit);
                     r_out_digit                 <= in_digit;
                     r_out_last                  <= 1'b0;
                     r_out_valid                 <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            S_SWEEP_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_sweep_digit == 4'd9) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_sweep_digit <= w_next_digit;
                     if (SWEEP_GAP == 0) begin
                        {r_out_edges, r_out_curves} <= feature(w_next_digit);
                        r_out_digit                 <= w_next_digit;
                        r_out_last                  <= (w_next_digit == 4'd9);
                        r_out_valid                 <= 1'b1;
                     end else begin
                        r_gap_cnt <= 4'd0;
                        r_state   <= S_GAP;
                     end
                  end
               end
            end
            S_GAP: begin
               // Data registers keep the previous item until the gap expires.
               if (r_gap_cnt == GAP_LAST) begin
                  r_gap_cnt                   <= 4'd0;
                  r_state                     <= S_SWEEP_HOLD;
                  {r_out_edges, r_out_curves} <= feature(r_sweep_digit);
                  r_out_digit                 <= r_sweep_digit;
                  r_out_last                  <= (r_sweep_digit == 4'd9);
                  r_out_valid                 <= 1'b1;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_digit_feature_gen.sv
// tb/tb_digit_feature_gen.sv - scoreboard bench for digit_feature_gen
// Expected pairs are queued at stimulus time and checked while out_valid is high.
module tb_digit_feature_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_digit = 4'd0;
   logic       in_ready;
   logic       sweep_start = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] out_edges;
   logic [3:0] out_curves;
   logic [3:0] out_digit;
   logic       out_last;
   logic       err;

   typedef struct {
      int d;
      int e;
      int c;
      int l;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   edges_t[10]  = '{0, 1, 1, 0, 3, 2, 0, 2, 0, 1};
   int   curves_t[10] = '{4, 0, 1, 2, 0, 1, 3, 0, 6, 2};

   digit_feature_gen #(.SWEEP_GAP(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_digit   (in_digit),
      .in_ready   (in_ready),
      .sweep_start(sweep_start),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_edges  (out_edges),
      .out_curves (out_curves),
      .out_digit  (out_digit),
      .out_last   (out_last),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_item(input int d, input int last);
      exp_t x;
      x.d = d;
      x.e = edges_t[d];
      x.c = curves_t[d];
      x.l = last;
      q.push_back(x);
   endtask

   task automatic push_sweep();
      for (int i = 0; i < 10; i++) push_item(i, (i == 9) ? 1 : 0);
   endtask

   // Scoreboard: every valid cycle must match the head item; pop on handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            check("digit",  int'(out_digit),  q[0].d);
            check("edges",  int'(out_edges),  q[0].e);
            check("curves", int'(out_curves), q[0].c);
            check("last",   int'(out_last),   q[0].l);
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      int n_busy;
      int n_gap;
      int n_valid;
      int found;

      // Reset state
      @(posedge clk);
      #2;
      check("rst_in_ready",  int'(in_ready),   1);
      check("rst_out_valid", int'(out_valid),  0);
      check("rst_edges",     int'(out_edges),  0);
      check("rst_curves",    int'(out_curves), 0);
      check("rst_digit",     int'(out_digit),  0);
      check("rst_last",      int'(out_last),   0);
      check("rst_err",       int'(err),        0);
      step();
      rst_n = 1'b1;
      step();

      // Single request, digit 4, consumer ready
      out_ready = 1'b1;
      push_item(4, 0);
      in_valid = 1'b1;
      in_digit = 4'd4;
      step();
      in_valid = 1'b0;
      check("t1_in_ready_busy", int'(in_ready), 0);
      check("t1_valid", int'(out_valid), 1);
      step();
      check("t1_idle_ready", int'(in_ready), 1);
      check("t1_valid_drop", int'(out_valid), 0);
      check("t1_q_empty", q.size(), 0);

      // Digit 8 held with consumer stalled; request during hold ignored
      out_ready = 1'b0;
      push_item(8, 0);
      in_valid = 1'b1;
      in_digit = 4'd8;
      step();
      in_digit = 4'd1;
      for (int i = 0; i < 5; i++) begin
         check("t2_held_valid", int'(out_valid), 1);
         check("t2_in_ready", int'(in_ready), 0);
         if (i == 3) in_valid = 1'b0;
         step();
      end
      out_ready = 1'b1;
      step();
      check("t2_idle_ready", int'(in_ready), 1);
      check("t2_q_empty", q.size(), 0);
      step();
      check("t2_no_extra", int'(out_valid), 0);

      // Illegal digit
      in_valid = 1'b1;
      in_digit = 4'd12;
      step();
      in_valid = 1'b0;
      check("t3_err", int'(err), 1);
      check("t3_valid", int'(out_valid), 0);
      check("t3_in_ready", int'(in_ready), 1);
      step();
      check("t3_err_clear", int'(err), 0);
      check("t3_valid2", int'(out_valid), 0);

      // Sweep with priority over a simultaneous request
      push_sweep();
      out_ready   = 1'b1;
      sweep_start = 1'b1;
      in_valid    = 1'b1;
      in_digit    = 4'd5;
      step();
      sweep_start = 1'b0;
      in_valid    = 1'b0;
      n_busy = 0;
      n_gap  = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) break;
         n_busy++;
         if (!out_valid) n_gap++;
      end
      check("t4_sweep_cycles", n_busy, 28);
      check("t4_gap_cycles", n_gap, 18);
      step();
      check("t4_q_empty", q.size(), 0);

      // Sweep under random backpressure
      push_sweep();
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      found = 0;
      for (int i = 0; i < 600; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         step();
         if (in_ready) begin
            found = 1;
            break;
         end
      end
      check("t5_finished", found, 1);
      check("t5_q_empty", q.size(), 0);

      // Reset during sweep item 3
      out_ready = 1'b1;
      push_sweep();
      sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      found = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid && out_digit == 4'd3) begin
            found = 1;
            break;
         end
      end
      check("t6_saw_item3", found, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid",  int'(out_valid),  0);
      check("t6_rst_edges",  int'(out_edges),  0);
      check("t6_rst_curves", int'(out_curves), 0);
      check("t6_rst_digit",  int'(out_digit),  0);
      check("t6_rst_ready",  int'(in_ready),   1);
      q.delete();
      step();
      rst_n = 1'b1;
      n_valid = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (out_valid) n_valid++;
      end
      check("t6_no_items", n_valid, 0);
      check("t6_in_ready", int'(in_ready), 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/digit_feature_gen.md
# digit_feature_gen

Feature-vector generator: the inverse of the digit classifier. Given a digit class 0–9, it emits the matching (edges, curves) feature pair that the classifier consumes. A sweep mode streams all ten digits in order for self-test. It sits upstream of the classifier on the tile, driven from the input pins, and presents features over a valid/ready stream.

## Interface
- `SWEEP_GAP`, default 2: idle cycles with `out_valid`=0 inserted between consecutive sweep items (0–15 legal).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  request carries a digit.
- `in_digit`  in  4  requested digit class.
- `in_ready`  out  1  block accepts a request this cycle.
- `sweep_start`  in  1  start a 0..9 sweep; level, sampled only in IDLE.
- `out_valid`  out  1  feature pair valid.
- `out_ready`  in  1  consumer accepts the pair.
- `out_edges`  out  3  straight-stroke count.
- `out_curves`  out  4  curved-stroke count.
- `out_digit`  out  4  digit tag of the current pair.
- `out_last`  out  1  current pair is the final sweep item (digit 9).
- `err`  out  1  one-cycle pulse: an illegal digit was accepted.

## Operation
- Fixed feature table, as digit: edges/curves:
  - 0:0/4, 1:1/0, 2:1/1, 3:0/2, 4:3/0
  - 5:2/1, 6:0/3, 7:2/0, 8:0/6, 9:1/2
  - All pairs are unique.
- FSM states: IDLE, HOLD, GAP, SWEEP_HOLD.
- IDLE:
  - `in_ready`=1, derived combinationally from state.
  - If `sweep_start`=1: go to SWEEP_HOLD with digit 0, ignoring `in_valid`. `sweep_start` has priority.
  - Else if `in_valid`=1 and `in_digit`≤9: register the table entry and tag, then go to HOLD.
  - Else if `in_valid`=1 and `in_digit`>9: pulse `err` next cycle, produce no output, stay in IDLE.
- HOLD:
  - `out_valid`=1; all out fields stay stable until `out_valid`&`out_ready`.
  - On handshake, go to IDLE.
- SWEEP_HOLD:
  - `out_valid`=1 with the current sweep digit; `out_last`=1 only for digit 9.
  - On handshake with digit<9: increment the digit, then go to GAP, or directly to SWEEP_HOLD if `SWEEP_GAP`=0.
  - On handshake with digit 9: go to IDLE.
- GAP:
  - `out_valid`=0.
  - Counts `SWEEP_GAP` cycles, then goes to SWEEP_HOLD.
- `in_ready`=0 in every state except IDLE. `sweep_start` and `in_valid` outside IDLE are ignored, not queued.
- `out_*` data registers hold their last value when `out_valid`=0. Consumers must qualify them with `out_valid`.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State IDLE, `in_ready`=1.
  - `out_valid`, `out_edges`, `out_curves`, `out_digit`, `out_last`, `err`, sweep digit and gap counter all 0.
- Reset asserted mid-HOLD, SWEEP_HOLD or GAP aborts immediately. No output is emitted after deassertion until a new request.
- Single-request latency: accept at edge N, `out_valid`=1 from the cycle after edge N.
- Minimum single-request throughput: one pair per 2 cycles (accept cycle plus handshake cycle).
- `out_ready` held high throughout a sweep:
  - Each item is valid for exactly 1 cycle, followed by `SWEEP_GAP` idle cycles.
  - Total sweep is 10 + 9·`SWEEP_GAP` cycles from first `out_valid` to return to IDLE.
- `out_ready` low: data is held indefinitely. There is no timeout.
- `err` is high for exactly one cycle, the cycle after the illegal accept. `in_ready` stays 1 throughout.
- `out_ready`=1 while `out_valid`=0 has no effect.

## Test plan
- Reset, then request digit 4 with `out_ready`=1 → next cycle `out_valid`=1, edges=3, curves=0, digit=4, `out_last`=0. IDLE and `in_ready`=1 the following cycle.
- Request digit 8 with `out_ready`=0 for 5 cycles → edges=0, curves=6 held stable for all 5 cycles. `in_valid` with digit 1 during the hold is ignored. `out_ready`=1 → handshake, then IDLE.
- `in_digit`=12 with `in_valid` → `err` pulses for 1 cycle, `out_valid` stays 0, `in_ready` stays 1.
- `sweep_start`=1 together with `in_valid` digit 5, `SWEEP_GAP`=2, `out_ready`=1 → digits 0..9 emitted in order, each separated by 2 invalid cycles, all table values exact. `out_last`=1 only on digit 9. 28 cycles from first valid to IDLE.
- Sweep with `out_ready` toggling randomly → no item dropped or duplicated, fields stable while stalled.
- `rst_n` pulsed low during sweep item 3 → all outputs 0 immediately, `in_ready`=1 after release, no further sweep items.
